// File: rtl/row_data_loader.sv
// row_data_loader
// Collects a 32-bit word stream (valid/ready, start-of-frame flag) into
// 384-bit rows and issues one write strobe per row. Rows are addressed
// panel-major across a NUM_PANELS x NUM_ROWS frame. row_data and the
// addresses are registered. They change only when the last word of a row
// is captured, so they stay stable across the write strobe.
module row_data_loader #(
  parameter  int WORD_WIDTH    = 32,
  parameter  int WORDS_PER_ROW = 12,
  parameter  int NUM_ROWS      = 16,
  parameter  int NUM_PANELS    = 4,
  localparam int ROW_W         = WORD_WIDTH * WORDS_PER_ROW,
  localparam int ROW_AW        = $clog2(NUM_ROWS),
  localparam int PANEL_AW      = $clog2(NUM_PANELS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [ROW_W-1:0]      row_data,
  output logic [ROW_AW-1:0]     row_data_row_addr,
  output logic [PANEL_AW-1:0]   row_data_panel_addr,
  output logic                  row_data_write_enable,
  output logic                  frame_done,
  output logic                  sof_error,
  output logic [7:0]            frame_count
);

  localparam int IDX_W = $clog2(WORDS_PER_ROW);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_AW-1:0]   LAST_ROW   = ROW_AW'(NUM_ROWS - 1);
  localparam logic [PANEL_AW-1:0] LAST_PANEL = PANEL_AW'(NUM_PANELS - 1);

  typedef enum logic [1:0] {
    ST_RST_WAIT,
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_word_idx;
  logic [ROW_AW-1:0]      r_row;
  logic [PANEL_AW-1:0]    r_panel;

  // Words 0..WORDS_PER_ROW-2 of the row in progress. The final word goes
  // straight into row_data, so it needs no shadow slot.
  logic [WORDS_PER_ROW-2:0][WORD_WIDTH-1:0] r_shadow;

  logic                   r_in_ready;
  logic [ROW_W-1:0]       r_row_data;
  logic [ROW_AW-1:0]      r_row_addr;
  logic [PANEL_AW-1:0]    r_panel_addr;
  logic                   r_write_enable;
  logic                   r_frame_done;
  logic                   r_sof_error;
  logic [7:0]             r_frame_count;

  logic                   w_xfer;
  logic                   w_sof_xfer;
  logic                   w_data_xfer;
  logic                   w_frame_end;

  // A transfer happens only while the loader advertises ready.
  // in_sof is therefore ignored whenever in_valid or in_ready is low.
  assign w_xfer      = in_valid & r_in_ready;
  assign w_sof_xfer  = w_xfer & in_sof;
  assign w_data_xfer = w_xfer & ~in_sof & (r_state == ST_COLLECT);
  assign w_frame_end = (r_row == LAST_ROW) && (r_panel == LAST_PANEL);

  // Shadow buffer: a start-of-frame word always lands in slot 0. Later
  // words land in their slot, except the last word of a row.
  // NOTE: this buffer has no reset. Every slot is rewritten before row_data
  // ever reads it, so clearing it would only add load to the reset net.
  always_ff @(posedge clk) begin
    if (w_sof_xfer) begin
      r_shadow[0] <= in_data;
    end else if (w_data_xfer && (r_word_idx != LAST_IDX)) begin
      r_shadow[r_word_idx] <= in_data;
    end
  end

  // Control FSM with registered handshake, strobes, row register and counters.
  // NOTE: all state here uses non-blocking assignments. Every register then
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_RST_WAIT;
      r_word_idx     <= '0;
      r_row          <= '0;
      r_panel        <= '0;
      r_in_ready     <= 1'b0;
      r_row_data     <= '0;
      r_row_addr     <= '0;
      r_panel_addr   <= '0;
      r_write_enable <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sof_error    <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_write_enable <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sof_error    <= 1'b0;

      unique case (r_state)
        ST_RST_WAIT: begin
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end

        ST_IDLE: begin
          // Words without in_sof are consumed and dropped. A frame opens on in_sof.
          if (w_sof_xfer) begin
            r_word_idx <= IDX_W'(1);
            r_row      <= '0;
            r_panel    <= '0;
            r_state    <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (w_sof_xfer) begin
            // Resync: drop the partial row, restart the frame at p0r0.
            r_sof_error <= 1'b1;
            r_word_idx  <= IDX_W'(1);
            r_row       <= '0;
            r_panel     <= '0;
          end else if (w_data_xfer) begin
            if (r_word_idx == LAST_IDX) begin
              r_row_data     <= {in_data, r_shadow};
              r_row_addr     <= r_row;
              r_panel_addr   <= r_panel;
              r_write_enable <= 1'b1;
              r_in_ready     <= 1'b0;
              r_word_idx     <= '0;
              r_state        <= ST_WRITE;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end

        ST_WRITE: begin
          r_in_ready <= 1'b1;
          if (w_frame_end) begin
            r_row         <= '0;
            r_panel       <= '0;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= ST_IDLE;
          end else begin
            if (r_row == LAST_ROW) begin
              r_row   <= '0;
              r_panel <= r_panel + 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
            r_state <= ST_COLLECT;
          end
        end

        default: begin
          r_in_ready <= 1'b0;
          r_state    <= ST_RST_WAIT;
        end
      endcase
    end
  end

  assign in_ready              = r_in_ready;
  assign row_data              = r_row_data;
  assign row_data_row_addr     = r_row_addr;
  assign row_data_panel_addr   = r_panel_addr;
  assign row_data_write_enable = r_write_enable;
  assign frame_done            = r_frame_done;
  assign sof_error             = r_sof_error;
  assign frame_count           = r_frame_count;

endmodule

// File: tb/tb_row_data_loader.sv
// Bench for row_data_loader. It drives one shared stream into two
// instances: a full-size loader (4 panels x 16 rows) and a reduced one
// (2 x 2). The reduced one makes the 256-frame counter wrap affordable.
// Expected behaviour comes from a word-queue model. For each instance the
// model tracks whether a frame is open, the words of the row in progress,
// and the linear row number within the frame.
module tb_row_data_loader;

  localparam int WW  = 32;
  localparam int WPR = 12;
  localparam int RW  = WW * WPR;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b1;
  logic [WW-1:0] in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_sof   = 1'b0;

  logic          a_ready, a_we, a_done, a_err;
  logic [RW-1:0] a_row_data;
  logic [3:0]    a_row;
  logic [1:0]    a_panel;
  logic [7:0]    a_count;

  logic          b_ready, b_we, b_done, b_err;
  logic [RW-1:0] b_row_data;
  logic          b_row;
  logic          b_panel;
  logic [7:0]    b_count;

  always #5 clk = ~clk;

  row_data_loader u_dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_sof                (in_sof),
    .in_ready              (a_ready),
    .row_data              (a_row_data),
    .row_data_row_addr     (a_row),
    .row_data_panel_addr   (a_panel),
    .row_data_write_enable (a_we),
    .frame_done            (a_done),
    .sof_error             (a_err),
    .frame_count           (a_count)
  );

  row_data_loader #(.NUM_ROWS(2), .NUM_PANELS(2)) u_small (
    .clk                   (clk),
    .reset_n               (reset_n),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_sof                (in_sof),
    .in_ready              (b_ready),
    .row_data              (b_row_data),
    .row_data_row_addr     (b_row),
    .row_data_panel_addr   (b_panel),
    .row_data_write_enable (b_we),
    .frame_done            (b_done),
    .sof_error             (b_err),
    .frame_count           (b_count)
  );

  // ---------------- reference model (index 0 = full size, 1 = small) ----
  bit            m_boot     [2];
  bit            m_in_frame [2];
  logic [WW-1:0] m_buf      [2][WPR];
  int            m_cnt      [2];
  int            m_row_idx  [2];
  bit            m_acc      [2];

  bit            e_ready [2];
  bit            e_we    [2];
  bit            e_done  [2];
  bit            e_err   [2];
  logic [RW-1:0] e_data  [2];
  int            e_row   [2];
  int            e_panel [2];
  int            e_count [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit gap_track = 0;
  int last_we   = -1;
  int notready_a, obs_we_a, obs_done_a, obs_err_a, obs_done_b;

  function automatic int rows_of(input int d);
    return (d == 0) ? 16 : 2;
  endfunction

  function automatic int panels_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_boot[d]     = 1'b1;
      m_in_frame[d] = 1'b0;
      m_cnt[d]      = 0;
      m_row_idx[d]  = 0;
      m_acc[d]      = 1'b0;
      e_ready[d]    = 1'b0;
      e_we[d]       = 1'b0;
      e_done[d]     = 1'b0;
      e_err[d]      = 1'b0;
      e_data[d]     = '0;
      e_row[d]      = 0;
      e_panel[d]    = 0;
      e_count[d]    = 0;
    end
  endtask

  // Advance one instance's model across a rising edge.
  task automatic model_edge(input int d, input bit v, input logic [WW-1:0] data, input bit sof);
    bit xfer;
    bit was_we;
    xfer      = v && e_ready[d];
    was_we    = e_we[d];
    m_acc[d]  = xfer;
    e_we[d]   = 1'b0;
    e_done[d] = 1'b0;
    e_err[d]  = 1'b0;
    if (m_boot[d]) begin
      m_boot[d]  = 1'b0;
      e_ready[d] = 1'b1;
    end else if (was_we) begin
      e_ready[d] = 1'b1;
      if (m_row_idx[d] == rows_of(d) * panels_of(d)) begin
        e_done[d]     = 1'b1;
        e_count[d]    = (e_count[d] + 1) % 256;
        m_in_frame[d] = 1'b0;
        m_row_idx[d]  = 0;
      end
    end else if (xfer) begin
      if (sof) begin
        if (m_in_frame[d]) e_err[d] = 1'b1;
        m_in_frame[d] = 1'b1;
        m_row_idx[d]  = 0;
        m_buf[d][0]   = data;
        m_cnt[d]      = 1;
      end else if (m_in_frame[d]) begin
        m_buf[d][m_cnt[d]] = data;
        m_cnt[d]++;
        if (m_cnt[d] == WPR) begin
          for (int k = 0; k < WPR; k++) e_data[d][k*WW +: WW] = m_buf[d][k];
          e_row[d]   = m_row_idx[d] % rows_of(d);
          e_panel[d] = m_row_idx[d] / rows_of(d);
          m_row_idx[d]++;
          e_we[d]    = 1'b1;
          e_ready[d] = 1'b0;
          m_cnt[d]   = 0;
        end
      end
    end
  endtask

  // ---------------- checking ---------------------------------------------
  task automatic check(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    assert (act === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    check("a_in_ready",   RW'(a_ready),    RW'(e_ready[0]));
    check("a_write_en",   RW'(a_we),       RW'(e_we[0]));
    check("a_row_data",   a_row_data,      e_data[0]);
    check("a_row_addr",   RW'(a_row),      RW'(e_row[0]));
    check("a_panel_addr", RW'(a_panel),    RW'(e_panel[0]));
    check("a_frame_done", RW'(a_done),     RW'(e_done[0]));
    check("a_sof_error",  RW'(a_err),      RW'(e_err[0]));
    check("a_frame_cnt",  RW'(a_count),    RW'(e_count[0]));
    check("b_in_ready",   RW'(b_ready),    RW'(e_ready[1]));
    check("b_write_en",   RW'(b_we),       RW'(e_we[1]));
    check("b_row_data",   b_row_data,      e_data[1]);
    check("b_row_addr",   RW'(b_row),      RW'(e_row[1]));
    check("b_panel_addr", RW'(b_panel),    RW'(e_panel[1]));
    check("b_frame_done", RW'(b_done),     RW'(e_done[1]));
    check("b_sof_error",  RW'(b_err),      RW'(e_err[1]));
    check("b_frame_cnt",  RW'(b_count),    RW'(e_count[1]));
  endtask

  // ---------------- stimulus helpers (called at the falling edge) --------
  task automatic cycle(input bit v, input logic [WW-1:0] d, input bit s);
    in_valid = v;
    in_data  = d;
    in_sof   = s;
    @(posedge clk);
    if (reset_n) begin
      model_edge(0, v, d, s);
      model_edge(1, v, d, s);
    end
    #1;
    cyc++;
    check_all();
    obs_we_a   += int'(a_we);
    obs_done_a += int'(a_done);
    obs_err_a  += int'(a_err);
    obs_done_b += int'(b_done);
    if (gap_track) begin
      if (!a_ready) notready_a++;
      if (a_we) begin
        if (last_we >= 0) check("strobe_spacing", RW'(cyc - last_we), RW'(13));
        last_we = cyc;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // Hold one word on the bus until instance 'tgt' takes it (bounded).
  task automatic send_word(input int tgt, input logic [WW-1:0] d, input bit s);
    bit done;
    int tries;
    done  = 1'b0;
    tries = 0;
    while (!done && tries < 20) begin
      cycle(1'b1, d, s);
      done = m_acc[tgt];
      tries++;
    end
    check("word_accepted", RW'(done), RW'(1));
  endtask

  // Send n words, sof on the first. Values are either w or random. With
  // gaps, idle cycles are inserted, and a sof word is offered during
  // each strobe cycle (it must be ignored by the full-size loader).
  task automatic send_frame(input int tgt, input int n, input bit rnd, input bit gaps);
    for (int w = 0; w < n; w++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      send_word(tgt, rnd ? WW'($urandom) : WW'(w), w == 0);
      if (gaps && (w % WPR) == WPR - 1) cycle(1'b1, $urandom, 1'b1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, $urandom, 1'b1);
    reset_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    model_reset();
    #3;
    do_reset();

    // Frame A: 768 back-to-back words, word w = w.
    gap_track  = 1'b1;
    last_we    = -1;
    notready_a = 0;
    obs_we_a   = 0;
    obs_done_a = 0;
    send_frame(0, 768, 1'b0, 1'b0);
    gap_track = 1'b0;
    check("A_notready_cycles", RW'(notready_a), RW'(64));
    check("A_strobes", RW'(obs_we_a), RW'(64));
    idle(2);
    check("A_frame_count", RW'(a_count), RW'(1));
    check("A_done_pulses", RW'(obs_done_a), RW'(1));

    // 5 words without sof are dropped. The next frame is resynced at word 30.
    obs_err_a = 0;
    for (int i = 0; i < 5; i++) send_word(0, $urandom, 1'b0);
    send_frame(0, 30, 1'b1, 1'b1);
    check("B_no_error_on_first_sof", RW'(obs_err_a), RW'(0));
    send_frame(0, 768, 1'b1, 1'b1);
    idle(2);
    check("B_sof_error_pulses", RW'(obs_err_a), RW'(1));
    check("B_frame_count", RW'(a_count), RW'(2));

    // Reset after word 7 of row 3. No strobe may follow; RST_WAIT -> IDLE.
    send_frame(0, 3 * WPR + 8, 1'b1, 1'b0);
    snap = obs_we_a;
    do_reset();
    check("C_no_strobe_after_reset", RW'(obs_we_a - snap), RW'(0));
    send_frame(0, 768, 1'b1, 1'b1);
    idle(2);
    check("D_frame_count", RW'(a_count), RW'(1));

    // 256 frames into the reduced loader: frame_count wraps back to 0.
    do_reset();
    obs_done_b = 0;
    for (int f = 0; f < 256; f++) send_frame(1, 2 * 2 * WPR, 1'b1, 1'b0);
    idle(2);
    check("E_frame_count_wrap", RW'(b_count), RW'(0));
    check("E_done_pulses", RW'(obs_done_b), RW'(256));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
